nibbler_ctrl: RTL and testbench

Fetch/decode/execute sequencer for the NibblER 4-bit core. Pulls 8-bit instructions from a synchronous-read program ROM, drives the shared ALU's `opcode`, `A` and `B` inputs, and holds the accumulator, carry/zero flags and program counter. Also runs a valid/ready output port and two-byte conditional jumps. Sits between the program ROM and the ALU; the ALU stays purely combinational.

---
 rtl/nibbler_pkg.sv | 35 +++
 rtl/nibbler_alu.sv | 34 +++
 rtl/nibbler_alu_defs.sv | 11 +
 rtl/nibbler_outport.sv | 43 ++++
 rtl/nibbler_ctrl.sv | 147 ++++++++++++++
 tb/tb_nibbler_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/nibbler_pkg.sv
// Shared types for the NibblER core: instruction opcodes, sequencer states and byte fields.
package nibbler_pkg;

  localparam int INSTR_OP_MSB  = 7;
  localparam int INSTR_OP_LSB  = 4;
  localparam int INSTR_IMM_MSB = 3;
  localparam int INSTR_IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_NORI = 4'h3,
    OP_CMPI = 4'h4,
    OP_OUT  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_HALT = 4'hF
  } instr_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_FETCH_OP,
    ST_EXEC,
    ST_HALT
  } ctrl_state_t;

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/nibbler_alu.sv
// Purely combinational 4-bit ALU of the NibblER core.
`include "nibbler_alu_defs.sv"

module nibbler_alu (
  input  logic [2:0] opcode,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero
);

  logic [4:0] sum;

  // CMP reports a borrow in carry so that "acc < imm" is testable with JC.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = 4'd0;
    carry  = 1'b0;
    case (opcode)
      `ALU_LD:  result = b;
      `ALU_ADD: {carry, result} = sum;
      `ALU_NOR: result = ~(a | b);
      `ALU_CMP: begin
        result = a - b;
        carry  = (a < b);
      end
      `ALU_OUT: result = a;
      default:  result = 4'd0;
    endcase
    zero = (result == 4'd0);
  end

endmodule

// File: rtl/nibbler_alu_defs.sv
// ALU operation encodings shared by the NibblER ALU and everything that drives it.
`ifndef NIBBLER_ALU_DEFS_SV
`define NIBBLER_ALU_DEFS_SV

`define ALU_LD  3'd0
`define ALU_ADD 3'd1
`define ALU_NOR 3'd2
`define ALU_CMP 3'd3
`define ALU_OUT 3'd4

`endif

// File: rtl/nibbler_outport.sv
// Output port holding register: loads on OUT, holds until the consumer accepts it.
module nibbler_outport (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_req,
  input  logic [3:0] load_data,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic       busy
);

  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;

  // A new load is only refused while an unaccepted value is still parked here.
  assign busy = valid_q & ~out_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_req && !busy) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/nibbler_ctrl.sv
// Fetch/decode/execute sequencer of the NibblER core: owns PC, IR, accumulator and flags,
// drives the shared ALU and the output port.
`include "nibbler_alu_defs.sv"

module nibbler_ctrl
  import nibbler_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            halted,
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  output logic [2:0]      alu_opcode,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_out,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic [3:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      acc,
  output logic            flag_c,
  output logic            flag_z
);

  ctrl_state_t     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0]      acc_q, acc_d;
  logic            flag_c_q, flag_c_d;
  logic            flag_z_q, flag_z_d;

  logic [3:0]      op;
  logic [3:0]      dec_op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;
  logic            jump_taken;
  logic            out_load;
  logic            out_busy;
  logic            out_stall;

  assign op          = ir_q[INSTR_OP_MSB:INSTR_OP_LSB];
  assign dec_op      = rom_data[INSTR_OP_MSB:INSTR_OP_LSB];
  assign pc_inc      = pc_q + PC_W'(1);
  assign jump_target = PC_W'(rom_data);
  assign jump_taken  = (op == OP_JMP) || ((op == OP_JC) && flag_c_q) || ((op == OP_JZ) && flag_z_q);
  assign out_stall   = out_load && out_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= 8'd0;
      acc_q    <= 4'd0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  // The opcode is still on rom_data during DECODE, before IR has captured it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_jump(dec_op))        state_d = ST_FETCH_OP;
        else if (dec_op == OP_HALT) state_d = ST_HALT;
        else                        state_d = ST_EXEC;
      end
      ST_FETCH_OP: state_d = ST_EXEC;
      ST_EXEC:     state_d = out_stall ? ST_EXEC : ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (state_q == ST_DECODE) begin
      ir_d = rom_data;
      pc_d = pc_inc;
    end else if (state_q == ST_EXEC) begin
      case (op)
        OP_LDI: acc_d = alu_out;
        OP_ADDI, OP_NORI: begin
          acc_d    = alu_out;
          flag_c_d = alu_carry;
          flag_z_d = alu_zero;
        end
        OP_CMPI: begin
          flag_c_d = alu_carry;
          flag_z_d = alu_zero;
        end
        OP_JMP, OP_JC, OP_JZ: pc_d = jump_taken ? jump_target : pc_inc;
        default: pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_LDI:  alu_opcode = `ALU_LD;
      OP_ADDI: alu_opcode = `ALU_ADD;
      OP_NORI: alu_opcode = `ALU_NOR;
      OP_CMPI: alu_opcode = `ALU_CMP;
      OP_OUT:  alu_opcode = `ALU_OUT;
      default: alu_opcode = `ALU_NOR;
    endcase
    halted   = (state_q == ST_HALT);
    out_load = (state_q == ST_EXEC) && (op == OP_OUT);
  end

  nibbler_outport u_outport (
    .clk       (clk),
    .reset     (reset),
    .load_req  (out_load),
    .load_data (alu_out),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (out_busy)
  );

  assign rom_addr = pc_q;
  assign alu_a    = acc_q;
  assign alu_b    = ir_q[INSTR_IMM_MSB:INSTR_IMM_LSB];
  assign acc      = acc_q;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;

endmodule

// File: tb/tb_nibbler_ctrl.sv
// Self-checking bench for nibbler_ctrl with the real ALU, a synchronous ROM model and an
// instruction-level reference model of the NibblER program semantics.
module tb_nibbler_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       halted;
  logic [7:0] rom_addr;
  logic [7:0] rom_q;
  logic [2:0] alu_opcode;
  logic [3:0] alu_a, alu_b, alu_out;
  logic       alu_carry, alu_zero;
  logic [3:0] out_data;
  logic       out_valid;
  logic [3:0] acc;
  logic       flag_c, flag_z;

  logic       start_w = 1'b0;
  logic       out_ready_w = 1'b1;
  logic       halted_w;
  logic [2:0] rom_addr_w;
  logic [7:0] rom_w_q;
  logic [2:0] alu_opcode_w;
  logic [3:0] alu_a_w, alu_b_w, alu_out_w;
  logic       alu_carry_w, alu_zero_w;
  logic [3:0] out_data_w;
  logic       out_valid_w;
  logic [3:0] acc_w;
  logic       flag_c_w, flag_z_w;

  logic [7:0] rom   [256];
  logic [7:0] rom_w [8];
  logic [3:0] out_log[$];
  logic [3:0] exp_q[$];

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  nibbler_ctrl #(.PC_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .halted(halted),
    .rom_addr(rom_addr), .rom_data(rom_q),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z)
  );

  nibbler_alu alu (
    .opcode(alu_opcode), .a(alu_a), .b(alu_b),
    .result(alu_out), .carry(alu_carry), .zero(alu_zero)
  );

  nibbler_ctrl #(.PC_W(3)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .halted(halted_w),
    .rom_addr(rom_addr_w), .rom_data(rom_w_q),
    .alu_opcode(alu_opcode_w), .alu_a(alu_a_w), .alu_b(alu_b_w),
    .alu_out(alu_out_w), .alu_carry(alu_carry_w), .alu_zero(alu_zero_w),
    .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .acc(acc_w), .flag_c(flag_c_w), .flag_z(flag_z_w)
  );

  nibbler_alu alu_w (
    .opcode(alu_opcode_w), .a(alu_a_w), .b(alu_b_w),
    .result(alu_out_w), .carry(alu_carry_w), .zero(alu_zero_w)
  );

  // Synchronous-read program ROMs: data follows the address by one cycle.
  always @(posedge clk) begin
    rom_q   <= rom[rom_addr];
    rom_w_q <= rom_w[rom_addr_w];
  end

  // Record every completed handshake; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) out_log.push_back(out_data);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rand_ready = 1'b0;
    reset   = 1'b1;
    start   = 1'b0;
    start_w = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  // Instruction-level interpreter of a program held in rom[].
  task automatic model_run(output logic [3:0] e_acc, output logic e_c, output logic e_z,
                           output int e_cyc);
    int pc, a, c, z, op, imm, steps;
    bit done, taken;
    logic [7:0] b;
    pc = 0; a = 0; c = 0; z = 0; e_cyc = 0; steps = 0; done = 1'b0;
    exp_q.delete();
    while (!done && steps < 500) begin
      steps++;
      b   = rom[pc];
      op  = int'(b[7:4]);
      imm = int'(b[3:0]);
      pc  = (pc + 1) % 256;
      case (op)
        1: begin a = imm; e_cyc += 3; end
        2: begin a = a + imm; c = (a > 15) ? 1 : 0; a = a % 16; z = (a == 0) ? 1 : 0; e_cyc += 3; end
        3: begin a = 15 ^ (a | imm); c = 0; z = (a == 0) ? 1 : 0; e_cyc += 3; end
        4: begin c = (a < imm) ? 1 : 0; z = (a == imm) ? 1 : 0; e_cyc += 3; end
        5: begin exp_q.push_back(4'(a)); e_cyc += 3; end
        6, 7, 8: begin
          taken = (op == 6) || (op == 7 && c == 1) || (op == 8 && z == 1);
          pc = taken ? int'(rom[pc]) : (pc + 1) % 256;
          e_cyc += 4;
        end
        15: begin done = 1'b1; e_cyc += 2; end
        default: e_cyc += 3;
      endcase
    end
    e_acc = 4'(a);
    e_c   = 1'(c);
    e_z   = 1'(z);
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    clear_rom();
    rom[0] = 8'h21;
    do_reset();
    check_cnt++; if (acc !== 4'h0) $display("[TB] FAIL reset_acc: got %0h expected 0", acc); else pass_cnt++;
    check_cnt++; if ({flag_c, flag_z} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {flag_c, flag_z}); else pass_cnt++;
    check_cnt++; if (rom_addr !== 8'h00) $display("[TB] FAIL reset_pc: got %0h expected 0", rom_addr); else pass_cnt++;
    check_cnt++; if ({out_valid, out_data} !== 5'h00) $display("[TB] FAIL reset_outport: got %0h expected 0", {out_valid, out_data}); else pass_cnt++;
    check_cnt++; if (halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b expected 0", halted); else pass_cnt++;
    step(5);
    check_cnt++; if (rom_addr !== 8'h00) $display("[TB] FAIL idle_hold_pc: got %0h expected 0", rom_addr); else pass_cnt++;
    reset = 1'b1;
    start = 1'b1;
    step(1);
    reset = 1'b0;
    start = 1'b0;
    step(5);
    check_cnt++; if ({rom_addr, acc} !== 12'h000) $display("[TB] FAIL reset_beats_start: got %0h expected 0", {rom_addr, acc}); else pass_cnt++;
  endtask

  task automatic test_add_halt();
    int n;
    clear_rom();
    rom[0] = 8'h21; rom[1] = 8'h22; rom[2] = 8'hF0;
    out_ready = 1'b1;
    do_reset();
    pulse_start();
    step(3);
    check_cnt++; if (acc !== 4'h1) $display("[TB] FAIL add_first_acc: got %0h expected 1", acc); else pass_cnt++;
    step(3);
    check_cnt++; if (acc !== 4'h3) $display("[TB] FAIL add_second_acc: got %0h expected 3", acc); else pass_cnt++;
    n = 6;
    while (!halted && n < 100) begin step(1); n++; end
    check_cnt++; if (halted !== 1'b1) $display("[TB] FAIL add_halted: got %b expected 1", halted); else pass_cnt++;
    check_cnt++; if (n !== 8) $display("[TB] FAIL add_halt_cycles: got %0d expected 8", n); else pass_cnt++;
    check_cnt++; if (flag_c !== 1'b0) $display("[TB] FAIL add_carry: got %b expected 0", flag_c); else pass_cnt++;
    start = 1'b1;
    step(3);
    start = 1'b0;
    check_cnt++; if ({halted, rom_addr} !== 9'h103) $display("[TB] FAIL halt_sticky: got %0h expected 103", {halted, rom_addr}); else pass_cnt++;
  endtask

  task automatic test_carry();
    int n;
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h2A; rom[2] = 8'hF0;
    out_ready = 1'b1;
    do_reset();
    pulse_start();
    n = 0;
    while (!halted && n < 100) begin step(1); n++; end
    check_cnt++; if (halted !== 1'b1) $display("[TB] FAIL carry_halted: got %b expected 1", halted); else pass_cnt++;
    check_cnt++; if (acc !== 4'h3) $display("[TB] FAIL carry_acc: got %0h expected 3", acc); else pass_cnt++;
    check_cnt++; if ({flag_c, flag_z} !== 2'b10) $display("[TB] FAIL carry_flags: got %b expected 10", {flag_c, flag_z}); else pass_cnt++;
  endtask

  task automatic test_cond_jump();
    int n;
    logic [3:0] want_acc;
    for (int t = 0; t < 2; t++) begin
      clear_rom();
      rom[0] = 8'h14; rom[1] = (t == 0) ? 8'h44 : 8'h43; rom[2] = 8'h80; rom[3] = 8'h07;
      rom[4] = 8'h1F; rom[5] = 8'hF0; rom[7] = 8'h15; rom[8] = 8'hF0;
      want_acc = (t == 0) ? 4'h5 : 4'hF;
      out_ready = 1'b1;
      do_reset();
      pulse_start();
      step(6);
      check_cnt++; if ({acc, flag_z} !== {4'h4, (t == 0)}) $display("[TB] FAIL jz_cmp_state_%0d: got %0h expected %0h", t, {acc, flag_z}, {4'h4, (t == 0)}); else pass_cnt++;
      n = 6;
      while (!halted && n < 100) begin step(1); n++; end
      check_cnt++; if (acc !== want_acc) $display("[TB] FAIL jz_final_acc_%0d: got %0h expected %0h", t, acc, want_acc); else pass_cnt++;
      check_cnt++; if (n !== 15) $display("[TB] FAIL jz_cycles_%0d: got %0d expected 15", t, n); else pass_cnt++;
    end
  endtask

  task automatic test_out_stall();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h50; rom[2] = 8'h50; rom[3] = 8'hF0;
    out_ready = 1'b0;
    do_reset();
    out_log.delete();
    pulse_start();
    step(6);
    check_cnt++; if ({out_valid, out_data} !== 5'h13) $display("[TB] FAIL out_first: got %0h expected 13", {out_valid, out_data}); else pass_cnt++;
    step(6);
    check_cnt++; if ({out_valid, rom_addr, halted} !== {1'b1, 8'h03, 1'b0}) $display("[TB] FAIL out_stall_hold: got %0h expected %0h", {out_valid, rom_addr, halted}, {1'b1, 8'h03, 1'b0}); else pass_cnt++;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_cnt++; if ({out_valid, out_data} !== 5'h13) $display("[TB] FAIL out_second_load: got %0h expected 13", {out_valid, out_data}); else pass_cnt++;
    check_cnt++; if (out_log.size() !== 1) $display("[TB] FAIL out_handshake_count: got %0d expected 1", out_log.size()); else pass_cnt++;
    step(2);
    check_cnt++; if (halted !== 1'b1) $display("[TB] FAIL out_resume_halt: got %b expected 1", halted); else pass_cnt++;
    out_ready = 1'b1;
    step(2);
    check_cnt++; if ({out_valid, 32'(out_log.size())} !== {1'b0, 32'd2}) $display("[TB] FAIL out_drain: got valid %b count %0d expected valid 0 count 2", out_valid, out_log.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid_exec();
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h50; rom[2] = 8'h25; rom[3] = 8'hF0;
    out_ready = 1'b0;
    do_reset();
    pulse_start();
    step(8);
    check_cnt++; if ({acc, out_valid} !== {4'h5, 1'b1}) $display("[TB] FAIL midreset_pre: got %0h expected %0h", {acc, out_valid}, {4'h5, 1'b1}); else pass_cnt++;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_cnt++; if ({acc, flag_c, flag_z} !== 6'h00) $display("[TB] FAIL midreset_regs: got %0h expected 0", {acc, flag_c, flag_z}); else pass_cnt++;
    check_cnt++; if ({out_valid, out_data, halted, rom_addr} !== 14'h0) $display("[TB] FAIL midreset_port_pc: got %0h expected 0", {out_valid, out_data, halted, rom_addr}); else pass_cnt++;
    step(4);
    check_cnt++; if ({rom_addr, acc} !== 12'h000) $display("[TB] FAIL midreset_idle: got %0h expected 0", {rom_addr, acc}); else pass_cnt++;
  endtask

  task automatic test_pc_wrap();
    for (int i = 0; i < 8; i++) rom_w[i] = 8'h21;
    do_reset();
    start_w = 1'b1;
    step(1);
    start_w = 1'b0;
    step(21);
    check_cnt++; if ({rom_addr_w, acc_w} !== {3'd7, 4'h7}) $display("[TB] FAIL wrap_pre: got %0h expected %0h", {rom_addr_w, acc_w}, {3'd7, 4'h7}); else pass_cnt++;
    step(3);
    check_cnt++; if ({rom_addr_w, acc_w} !== {3'd0, 4'h8}) $display("[TB] FAIL wrap_post: got %0h expected %0h", {rom_addr_w, acc_w}, {3'd0, 4'h8}); else pass_cnt++;
    step(24);
    check_cnt++; if ({acc_w, flag_c_w, flag_z_w} !== {4'h0, 2'b11}) $display("[TB] FAIL wrap_acc_overflow: got %0h expected %0h", {acc_w, flag_c_w, flag_z_w}, {4'h0, 2'b11}); else pass_cnt++;
    step(12);
    check_cnt++; if ({acc_w, rom_addr_w, flag_c_w, flag_z_w} !== {4'h4, 3'd4, 2'b00}) $display("[TB] FAIL wrap_acc_mod16: got %0h expected %0h", {acc_w, rom_addr_w, flag_c_w, flag_z_w}, {4'h4, 3'd4, 2'b00}); else pass_cnt++;
    check_cnt++; if ({halted_w, out_valid_w, out_data_w} !== 6'h00) $display("[TB] FAIL wrap_idle_outputs: got %0h expected 0", {halted_w, out_valid_w, out_data_w}); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_random_programs();
    int ops[14] = '{0, 1, 1, 2, 2, 3, 4, 5, 5, 6, 7, 8, 9, 14};
    for (int it = 0; it < 10; it++) begin
      int nins, addr, op, cyc, n, tgt, lim;
      int starts[$];
      int jump_idx[$];
      logic [3:0] e_acc;
      logic e_c, e_z;
      clear_rom();
      addr = 0;
      nins = $urandom_range(8, 16);
      for (int i = 0; i < nins; i++) begin
        op = ops[$urandom_range(0, 13)];
        starts.push_back(addr);
        rom[addr] = {op[3:0], 4'($urandom_range(0, 15))};
        if (op >= 6 && op <= 8) begin
          jump_idx.push_back(i);
          addr += 2;
        end else begin
          addr += 1;
        end
      end
      starts.push_back(addr);
      rom[addr] = 8'hF0;
      foreach (jump_idx[j]) begin
        tgt = starts[$urandom_range(jump_idx[j] + 1, nins)];
        rom[starts[jump_idx[j]] + 1] = 8'(tgt);
      end
      model_run(e_acc, e_c, e_z, cyc);

      do_reset();
      out_ready = 1'b1;
      out_log.delete();
      rand_ready = (it >= 5);
      pulse_start();
      n = 0;
      while (!halted && n < 3000) begin step(1); n++; end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      step(3);

      check_cnt++; if (halted !== 1'b1) $display("[TB] FAIL rand%0d_halted: got %b expected 1", it, halted); else pass_cnt++;
      check_cnt++; if (acc !== e_acc) $display("[TB] FAIL rand%0d_acc: got %0h expected %0h", it, acc, e_acc); else pass_cnt++;
      check_cnt++; if ({flag_c, flag_z} !== {e_c, e_z}) $display("[TB] FAIL rand%0d_flags: got %b expected %b", it, {flag_c, flag_z}, {e_c, e_z}); else pass_cnt++;
      if (it < 5) begin
        check_cnt++; if (n !== cyc) $display("[TB] FAIL rand%0d_cycles: got %0d expected %0d", it, n, cyc); else pass_cnt++;
      end
      check_cnt++; if (out_log.size() !== exp_q.size()) $display("[TB] FAIL rand%0d_out_count: got %0d expected %0d", it, out_log.size(), exp_q.size()); else pass_cnt++;
      lim = (out_log.size() < exp_q.size()) ? out_log.size() : exp_q.size();
      for (int k = 0; k < lim; k++) begin
        check_cnt++; if (out_log[k] !== exp_q[k]) $display("[TB] FAIL rand%0d_out%0d: got %0h expected %0h", it, k, out_log[k], exp_q[k]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_halt();
    test_carry();
    test_cond_jump();
    test_out_stall();
    test_reset_mid_exec();
    test_pc_wrap();
    test_random_programs();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
